// File: rtl/geofence_poly.sv
// ---------------------------------------------------------------------------
// geofence_poly
//   Convex-polygon geofence. One job is a test point P followed by NV
//   unordered polygon vertices. The vertices are bubble-sorted into
//   counter-clockwise order about vertex 0. The edges are then walked, and
//   the block reports whether P lies inside the polygon. One signed
//   cross-product unit is shared between the sort and check phases.
//
// Parameters
//   CW        coordinate width (unsigned X/Y)
//   NV        vertex count, 3..8
//   INCL_EDGE 1: a point on an edge or vertex counts as inside
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   X, Y       in   coordinate of the point being transferred
//   in_valid   in   X/Y valid; transfer when in_valid && in_ready
//   in_ready   out  high in IDLE and LOAD
//   valid      out  one-cycle pulse while in DONE
//   is_inside  out  result of the most recent job, held until the next DONE
// ---------------------------------------------------------------------------
module geofence_poly #(
    parameter int CW        = 10,
    parameter int NV        = 6,
    parameter bit INCL_EDGE = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          valid,
    output logic          is_inside
);

    // Index width: enough to hold 0..NV-1 for NV in 3..8.
    localparam int IW = (NV > 4) ? 3 : 2;
    localparam int DW = CW + 1;        // signed coordinate difference
    localparam int PW = 2 * CW + 3;    // signed cross-product result

    localparam logic [IW-1:0] ZERO      = IW'(0);
    localparam logic [IW-1:0] ONE       = IW'(1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NV - 1);
    localparam logic [IW-1:0] SORT_LAST = IW'(NV - 2);
    localparam logic [IW-1:0] PASS_LAST = IW'(NV - 3);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SORT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Signed difference of two unsigned coordinates; never overflows.
    function automatic logic signed [DW-1:0] diff_f(
        input logic [CW-1:0] a,
        input logic [CW-1:0] b
    );
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // cross(a,b) = ax*by - bx*ay at full precision.
    function automatic logic signed [PW-1:0] cross_f(
        input logic signed [DW-1:0] ax,
        input logic signed [DW-1:0] ay,
        input logic signed [DW-1:0] bx,
        input logic signed [DW-1:0] by
    );
        logic signed [PW-2:0] axe;
        logic signed [PW-2:0] aye;
        logic signed [PW-2:0] bxe;
        logic signed [PW-2:0] bye;
        logic signed [PW-2:0] p1;
        logic signed [PW-2:0] p2;
        axe = $signed({{(CW+1){ax[DW-1]}}, ax});
        aye = $signed({{(CW+1){ay[DW-1]}}, ay});
        bxe = $signed({{(CW+1){bx[DW-1]}}, bx});
        bye = $signed({{(CW+1){by[DW-1]}}, by});
        p1  = axe * bye;
        p2  = bxe * aye;
        return $signed({p1[PW-2], p1}) - $signed({p2[PW-2], p2});
    endfunction

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] cnt_q,   cnt_d;     // load index k, sort step i, or edge e
    logic [IW-1:0] pass_q,  pass_d;    // bubble-sort pass number
    logic [CW-1:0] px_q,    px_d;
    logic [CW-1:0] py_q,    py_d;
    logic [CW-1:0] vx_q [NV];
    logic [CW-1:0] vy_q [NV];
    logic [CW-1:0] vx_d [NV];
    logic [CW-1:0] vy_d [NV];
    logic          neg_q,    neg_d;
    logic          zer_q,    zer_d;
    logic          valid_q,  valid_d;
    logic          inside_q, inside_d;

    logic                 in_ready_s;
    logic                 accept_s;
    logic [IW-1:0]        nxt_idx_s;
    logic signed [DW-1:0] ax_s, ay_s, bx_s, by_s;
    logic signed [PW-1:0] cross_s;
    logic                 cneg_s;
    logic                 czero_s;

    assign in_ready_s = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept_s   = in_valid && in_ready_s;
    // Successor index; the wrap only matters for the closing edge in CHECK,
    // since the sort step never reaches the last index.
    assign nxt_idx_s  = (cnt_q == LAST_IDX) ? ZERO : (cnt_q + ONE);

    // Operand select for the shared cross-product unit.
    always_comb begin
        ax_s = {DW{1'b0}};
        ay_s = {DW{1'b0}};
        bx_s = {DW{1'b0}};
        by_s = {DW{1'b0}};
        case (state_q)
            S_SORT: begin
                ax_s = diff_f(vx_q[cnt_q],     vx_q[0]);
                ay_s = diff_f(vy_q[cnt_q],     vy_q[0]);
                bx_s = diff_f(vx_q[nxt_idx_s], vx_q[0]);
                by_s = diff_f(vy_q[nxt_idx_s], vy_q[0]);
            end
            S_CHECK: begin
                ax_s = diff_f(vx_q[nxt_idx_s], vx_q[cnt_q]);
                ay_s = diff_f(vy_q[nxt_idx_s], vy_q[cnt_q]);
                bx_s = diff_f(px_q,            vx_q[cnt_q]);
                by_s = diff_f(py_q,            vy_q[cnt_q]);
            end
            default: begin
                ax_s = {DW{1'b0}};
                ay_s = {DW{1'b0}};
                bx_s = {DW{1'b0}};
                by_s = {DW{1'b0}};
            end
        endcase
    end

    assign cross_s = cross_f(ax_s, ay_s, bx_s, by_s);
    assign cneg_s  = cross_s[PW-1];
    assign czero_s = (cross_s == {PW{1'b0}});

    // Next-state logic: load, sort, edge check and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        px_d     = px_q;
        py_d     = py_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        neg_d    = neg_q;
        zer_d    = zer_q;
        valid_d  = 1'b0;
        inside_d = inside_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    px_d    = X;
                    py_d    = Y;
                    cnt_d   = ZERO;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    vx_d[cnt_q] = X;
                    vy_d[cnt_q] = Y;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_SORT;
                        cnt_d   = ONE;
                        pass_d  = ZERO;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_SORT: begin
                // A clockwise pair is out of order; collinear pairs stay put.
                if (cneg_s) begin
                    vx_d[cnt_q]     = vx_q[nxt_idx_s];
                    vy_d[cnt_q]     = vy_q[nxt_idx_s];
                    vx_d[nxt_idx_s] = vx_q[cnt_q];
                    vy_d[nxt_idx_s] = vy_q[cnt_q];
                end else begin
                    vx_d[cnt_q] = vx_q[cnt_q];
                end
                if (cnt_q == SORT_LAST) begin
                    if (pass_q == PASS_LAST) begin
                        state_d = S_CHECK;
                        cnt_d   = ZERO;
                        neg_d   = 1'b0;
                        zer_d   = 1'b0;
                    end else begin
                        cnt_d  = ONE;
                        pass_d = pass_q + ONE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_CHECK: begin
                neg_d = neg_q | cneg_s;
                zer_d = zer_q | czero_s;
                if (cnt_q == LAST_IDX) begin
                    // Fold in the closing edge's result directly so that
                    // is_inside is ready on the same edge that enters DONE.
                    state_d  = S_DONE;
                    cnt_d    = ZERO;
                    valid_d  = 1'b1;
                    inside_d = !(neg_q | cneg_s) &&
                               (INCL_EDGE || !(zer_q | czero_s));
                end else begin
                    cnt_d = nxt_idx_s;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = ZERO;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = ZERO;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= ZERO;
            pass_q   <= ZERO;
            px_q     <= {CW{1'b0}};
            py_q     <= {CW{1'b0}};
            neg_q    <= 1'b0;
            zer_q    <= 1'b0;
            valid_q  <= 1'b0;
            inside_q <= 1'b0;
            for (int i = 0; i < NV; i++) begin
                vx_q[i] <= {CW{1'b0}};
                vy_q[i] <= {CW{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            px_q     <= px_d;
            py_q     <= py_d;
            neg_q    <= neg_d;
            zer_q    <= zer_d;
            valid_q  <= valid_d;
            inside_q <= inside_d;
            for (int i = 0; i < NV; i++) begin
                vx_q[i] <= vx_d[i];
                vy_q[i] <= vy_d[i];
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign valid     = valid_q;
    assign is_inside = inside_q;

endmodule

// File: tb/tb_geofence_poly.sv
module tb_geofence_poly;

    logic clk;
    logic reset_n;

    // Bus A: NV=4, drives both the exclusive and inclusive-edge instances.
    logic [9:0] a_x, a_y;
    logic       a_v, a_rdy, a_val, a_in, e_rdy, e_val, e_in;
    // Bus B: NV=6.
    logic [9:0] b_x, b_y;
    logic       b_v, b_rdy, b_val, b_in;
    // Bus C: NV=3.
    logic [9:0] c_x, c_y;
    logic       c_v, c_rdy, c_val, c_in;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    int jx[8];
    int jy[8];

    geofence_poly #(.CW(10), .NV(4), .INCL_EDGE(1'b0)) u_sq (
        .clk(clk), .reset_n(reset_n), .X(a_x), .Y(a_y), .in_valid(a_v),
        .in_ready(a_rdy), .valid(a_val), .is_inside(a_in));
    geofence_poly #(.CW(10), .NV(4), .INCL_EDGE(1'b1)) u_sqe (
        .clk(clk), .reset_n(reset_n), .X(a_x), .Y(a_y), .in_valid(a_v),
        .in_ready(e_rdy), .valid(e_val), .is_inside(e_in));
    geofence_poly #(.CW(10), .NV(6), .INCL_EDGE(1'b0)) u_hex (
        .clk(clk), .reset_n(reset_n), .X(b_x), .Y(b_y), .in_valid(b_v),
        .in_ready(b_rdy), .valid(b_val), .is_inside(b_in));
    geofence_poly #(.CW(10), .NV(3), .INCL_EDGE(1'b0)) u_tri (
        .clk(clk), .reset_n(reset_n), .X(c_x), .Y(c_y), .in_valid(c_v),
        .in_ready(c_rdy), .valid(c_val), .is_inside(c_in));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input int x, input int y, input logic v);
        case (sel)
            0: begin a_x = x[9:0]; a_y = y[9:0]; a_v = v; end
            1: begin b_x = x[9:0]; b_y = y[9:0]; b_v = v; end
            default: begin c_x = x[9:0]; c_y = y[9:0]; c_v = v; end
        endcase
    endtask

    function automatic logic get_val(input int sel);
        case (sel)
            0: return a_val;
            1: return b_val;
            default: return c_val;
        endcase
    endfunction

    function automatic logic get_in(input int sel);
        case (sel)
            0: return a_in;
            1: return b_in;
            default: return c_in;
        endcase
    endfunction

    function automatic logic get_rdy(input int sel);
        case (sel)
            0: return a_rdy;
            1: return b_rdy;
            default: return c_rdy;
        endcase
    endfunction

    // Transfer P then jx/jy[0..nv-1]; returns after the accepting edge of the last vertex.
    task automatic load_job(input int sel, input int nv, input int px, input int py);
        @(negedge clk); drive(sel, px, py, 1'b1); @(posedge clk);
        for (int k = 0; k < nv; k++) begin
            @(negedge clk); drive(sel, jx[k], jy[k], 1'b1); @(posedge clk);
        end
        @(negedge clk); drive(sel, 0, 0, 1'b0);
    endtask

    task automatic run_job(input int sel, input int nv, input int px, input int py,
                           input int exp_lat, input logic exp_in, input logic exp_e,
                           input string tag);
        int lat;
        load_job(sel, nv, px, py);
        lat = 1;
        while (!get_val(sel) && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_inside"}, get_in(sel), exp_in);
        chk({tag, "_ready_in_done"}, get_rdy(sel), 1'b0);
        if (sel == 0) begin
            chk({tag, "_incl_valid"}, e_val, 1'b1);
            chk({tag, "_incl_inside"}, e_in, exp_e);
        end
        @(negedge clk);
        chk({tag, "_valid_pulse_end"}, get_val(sel), 1'b0);
        chk({tag, "_inside_hold"}, get_in(sel), exp_in);
    endtask

    int sqx[4] = '{0, 100, 100, 0};
    int sqy[4] = '{0, 0, 100, 100};
    int sx[15];
    int sy[15];
    int res_a[3];
    int res_e[3];
    int tp[3];
    int pulses;
    int idx;
    int vcount;

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 1'b0);
        drive(1, 0, 0, 1'b0);
        drive(2, 0, 0, 1'b0);
        #1;
        chk("reset_ready_sq", a_rdy, 1'b1);
        chk("reset_valid_sq", a_val, 1'b0);
        chk("reset_inside_sq", a_in, 1'b0);
        chk("reset_ready_hex", b_rdy, 1'b1);
        chk("reset_valid_tri", c_val, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Square fed in CCW order.
        for (int k = 0; k < 4; k++) begin jx[k] = sqx[k]; jy[k] = sqy[k]; end
        run_job(0, 4, 50, 50, 9, 1'b1, 1'b1, "sq_center");
        run_job(0, 4, 150, 50, 9, 1'b0, 1'b0, "sq_outside");
        run_job(0, 4, 100, 50, 9, 1'b0, 1'b1, "sq_edge");

        // Hexagon fed shuffled; v0 stays (200,100).
        jx[0] = 200; jy[0] = 100;
        jx[1] = 300; jy[1] = 300;
        jx[2] = 150; jy[2] = 200;
        jx[3] = 350; jy[3] = 200;
        jx[4] = 200; jy[4] = 300;
        jx[5] = 300; jy[5] = 100;
        run_job(1, 6, 160, 110, 23, 1'b0, 1'b0, "hex_outside");
        run_job(1, 6, 250, 200, 23, 1'b1, 1'b0, "hex_center");

        // Extreme-width triangle, first fed clockwise (forces a swap), then CCW.
        jx[0] = 0;    jy[0] = 0;
        jx[1] = 0;    jy[1] = 1023;
        jx[2] = 1023; jy[2] = 0;
        run_job(2, 3, 1, 1, 5, 1'b1, 1'b0, "tri_cw_inside");
        jx[1] = 1023; jy[1] = 0;
        jx[2] = 0;    jy[2] = 1023;
        run_job(2, 3, 1023, 1023, 5, 1'b0, 1'b0, "tri_far_corner");
        run_job(2, 3, 1, 1, 5, 1'b1, 1'b0, "tri_ccw_inside");

        // Reset pulsed mid-SORT on the hexagon (previous result was inside=1).
        jx[0] = 200; jy[0] = 100;
        jx[1] = 300; jy[1] = 300;
        jx[2] = 150; jy[2] = 200;
        jx[3] = 350; jy[3] = 200;
        jx[4] = 200; jy[4] = 300;
        jx[5] = 300; jy[5] = 100;
        load_job(1, 6, 250, 200);
        repeat (4) @(negedge clk);
        chk("hex_sort_not_ready", b_rdy, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ready", b_rdy, 1'b1);
        chk("rst_mid_inside", b_in, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (b_val) vcount++;
        end
        chk("rst_no_valid", vcount, 0);
        chk("rst_after_ready", b_rdy, 1'b1);
        chk("rst_after_inside", b_in, 1'b0);
        run_job(1, 6, 250, 200, 23, 1'b1, 1'b0, "hex_after_reset");

        // Three streamed square jobs; in_valid toggles with junk while not ready.
        for (int j = 0; j < 3; j++) begin
            sx[j*5] = (j == 1) ? 150 : ((j == 2) ? 100 : 50);
            sy[j*5] = 50;
            for (int k = 0; k < 4; k++) begin
                sx[j*5+1+k] = sqx[k];
                sy[j*5+1+k] = sqy[k];
            end
        end
        idx = 0;
        pulses = 0;
        for (int c = 0; c < 200 && pulses < 3; c++) begin
            @(negedge clk);
            if (a_val) begin
                res_a[pulses] = a_in;
                res_e[pulses] = e_in;
                tp[pulses] = c;
                pulses++;
            end
            if (a_rdy && idx < 15) begin
                drive(0, sx[idx], sy[idx], 1'b1);
                idx++;
            end else begin
                drive(0, 1023, 1023, c[0]);
            end
        end
        drive(0, 0, 0, 1'b0);
        chk("stream_pulses", pulses, 3);
        chk("stream_job1", res_a[0], 1);
        chk("stream_job2", res_a[1], 0);
        chk("stream_job3", res_a[2], 0);
        chk("stream_job3_incl", res_e[2], 1);
        chk("stream_gap12", tp[1] - tp[0], 14);
        chk("stream_gap23", tp[2] - tp[1], 14);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
